mmio_gpio_responder: RTL
========================

Name: mmio_gpio_responder

Overview:
- Memory-mapped GPIO peripheral that answers the loads and stores the MEM stage issues to the I/O window.
- Owns the LED output register.
- Synchronizes and debounces the physical switches.
- Captures switch rising edges in a sticky write-1-to-clear status register.
- Returns read data through a registered one-cycle req/ack handshake.
- Sits between the MEM stage bus port and the board pins.

Parameters:
- BASE_ADDR, 32'h00000010, byte address of the first register; must be 16-byte aligned.
- NUM_SW, 4, number of switch inputs and LED outputs (1..8).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples needed to accept a switch change (>=2).
- CNT_W, 16, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-low reset.
- bus_req  in  1  access request, one cycle per access.
- bus_we  in  1  1 = store, 0 = load; sampled with bus_req.
- bus_addr  in  32  byte address; sampled with bus_req.
- bus_wdata  in  32  store data.
- bus_rdata  out  32  load data; valid while bus_ack = 1.
- bus_ack  out  1  access complete.
- bus_err  out  1  unmapped address; qualified by bus_ack.
- sw_pins  in  NUM_SW  raw asynchronous switch inputs.
- led_pins  out  NUM_SW  LED drive.
- irq  out  1  interrupt request; constant 0 unless SWITCH_IRQ_EN is defined.

Behaviour:
- Reset (rst = 0, asynchronous) sets:
  - bus_rdata, bus_ack, bus_err, led_pins, edge_status, irq_mask, irq to 0.
  - Sync flops, stable switch state and debounce counters to 0.
- Register map, word offsets from BASE_ADDR:
  - +0x0 SWITCH: RO, debounced state zero-extended.
  - +0x4 LED: RW, bits [NUM_SW-1:0].
  - +0x8 EDGE_STATUS: RO / W1C.
  - +0xC IRQ_MASK: RW, present only with the macro.
- Address decode: full 32-bit compare. bus_addr[1:0] != 0 or an unmapped offset counts as an error access.
- Handshake:
  - bus_req at edge N gives bus_ack = 1 for exactly the cycle after edge N, with bus_rdata/bus_err valid in that cycle.
  - Requests may arrive every cycle; each gets its own ack. There is no back-pressure.
  - bus_rdata is 0 whenever bus_ack = 0, and on errored or write accesses.
- Stores:
  - Take effect at the request edge.
  - LED <= wdata[NUM_SW-1:0].
  - EDGE_STATUS clears the bits set in wdata.
  - Writes to SWITCH are ignored without error.
  - Error stores change no state.
- Loads: return the register value as it was before any same-edge update.
- Switch path, per bit:
  - Two-flop synchronizer, then a counter.
  - While sync == stable, the counter is held at 0.
  - While they differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the difference still present: stable <= sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Edge capture: a stable 0->1 transition sets the EDGE_STATUS bit. If a set and a W1C land on the same bit in the same cycle, the set wins.
- Total latency, pin change to SWITCH readable: 2 + DEBOUNCE_CYCLES cycles.
- Reset mid-access: the ack is dropped, and no state change survives reset.

Optional Feature:
- Macro: SWITCH_IRQ_EN.
- Defined:
  - IRQ_MASK register exists at +0xC.
  - irq is registered and equals |(EDGE_STATUS & IRQ_MASK), one cycle after the status or mask changes.
- Undefined:
  - irq is tied to 0.
  - +0xC decodes as unmapped and returns bus_err = 1.

Decomposition:
- Shared package gpio_pkg holds:
  - Register offset constants: OFF_SWITCH, OFF_LED, OFF_EDGE, OFF_IRQ_MASK.
  - Default BASE_ADDR.
  - These are reused by the MEM stage address compare and by the testbench.
- One sub-module: sw_debounce, a single-bit synchronizer plus counter with parameter DEBOUNCE_CYCLES, instantiated NUM_SW times via generate.

Test Plan:
- Reset then write LED: hold rst = 0 for 3 cycles, release, store 0x0000000A to 0x14 -> led_pins = 4'b1010 from the cycle after req; load 0x14 -> ack next cycle, rdata = 0x0000000A, err = 0.
- Debounce: sw_pins 0000 -> 0101 held -> load 0x10 returns 0 until 18 cycles after the change, then 0x00000005. A 10-cycle pulse on bit 3 never appears.
- Edge W1C: after the debounced rise of bits 0 and 2, load 0x18 -> 0x5; store 0x1 to 0x18 -> load returns 0x4. A new bit-0 rise coinciding with a W1C of bit 0 -> bit 0 remains 1.
- Back-to-back: req on 4 consecutive cycles (LED write 0x3, LED read, SWITCH read, read of 0x20) -> 4 consecutive acks; LED read returns 0x3; 0x20 read gives err = 1, rdata = 0. A misaligned read at 0x11 also gives err = 1.
- IRQ, with SWITCH_IRQ_EN: store 0x2 to 0x1C, debounce a rise on bit 1 -> irq = 1 one cycle after the status bit sets; W1C 0x2 -> irq = 0 one cycle later. Without the macro: irq stays 0 and a read of 0x1C gives err = 1.
- Async reset mid-activity: assert rst between clock edges while LED = 0xF and edges are pending -> led_pins, edge_status and bus_ack go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_gpio_responder_pkg.sv
// Shared GPIO register map: offsets, default base address and the address decoder
// used by the responder, the MEM stage address compare and the testbench.
package gpio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0010;

  localparam logic [3:0] OFF_SWITCH   = 4'h0;
  localparam logic [3:0] OFF_LED      = 4'h4;
  localparam logic [3:0] OFF_EDGE     = 4'h8;
  localparam logic [3:0] OFF_IRQ_MASK = 4'hC;

  typedef enum logic [2:0] {
    SEL_SWITCH   = 3'd0,
    SEL_LED      = 3'd1,
    SEL_EDGE     = 3'd2,
    SEL_IRQ_MASK = 3'd3,
    SEL_NONE     = 3'd4
  } reg_sel_e;

  // Full 32-bit compare; base and offsets are word aligned, so a misaligned address never matches.
  function automatic reg_sel_e decode_addr(input logic [31:0] base,
                                           input logic [31:0] addr,
                                           input logic        irq_en);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (addr == base + {28'h000_0000, OFF_SWITCH}) begin
      sel = SEL_SWITCH;
    end else if (addr == base + {28'h000_0000, OFF_LED}) begin
      sel = SEL_LED;
    end else if (addr == base + {28'h000_0000, OFF_EDGE}) begin
      sel = SEL_EDGE;
    end else if (irq_en && (addr == base + {28'h000_0000, OFF_IRQ_MASK})) begin
      sel = SEL_IRQ_MASK;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mmio_gpio_responder_if.sv
// MEM stage to GPIO responder bus: single-cycle request, registered ack/rdata/err.
interface mmio_gpio_responder_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);

endinterface

// File: rtl/mmio_gpio_responder_sw_debounce.sv
// One switch bit: two-flop synchronizer followed by a stability counter.
// rise pulses on the clock where the debounced state is about to go 0 -> 1.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 32'd16,
  parameter int CNT_W           = 32'd16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic rise
);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             differ_s;
  logic             done_s;

  // Accept state change when the difference has persisted for the full window.
  always_comb begin
    differ_s = sync2_r ^ stable_r;
    done_s   = differ_s && (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 32'd1));
  end

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pin;
      sync2_r <= sync1_r;
    end
  end

  // Stability counter and debounced state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      stable_r <= 1'b0;
    end else if (!differ_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (done_s) begin
      stable_r <= sync2_r;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

  assign stable = stable_r;
  assign rise   = done_s & sync2_r;

endmodule

// File: rtl/mmio_gpio_responder.sv
// Memory-mapped GPIO: LED register, debounced switches, sticky W1C edge status.
// Build macro SWITCH_IRQ_EN adds the IRQ_MASK register and a live irq output.
module mmio_gpio_responder
  import gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int          NUM_SW          = 32'd4,
  parameter int          DEBOUNCE_CYCLES = 32'd16,
  parameter int          CNT_W           = 32'd16
) (
  input  logic                       clk,
  input  logic                       rst,
  mmio_gpio_responder_if.slave       bus,
  input  logic [NUM_SW-1:0]          sw_pins,
  output logic [NUM_SW-1:0]          led_pins,
  output logic                       irq
);

`ifdef SWITCH_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic [NUM_SW-1:0] stable_s;
  logic [NUM_SW-1:0] rise_s;
  logic [NUM_SW-1:0] led_r;
  logic [NUM_SW-1:0] edge_r;
  logic [NUM_SW-1:0] mask_s;
  logic [NUM_SW-1:0] clr_s;
  logic [NUM_SW-1:0] edge_next_s;
  logic [31:0]       rd_data_s;
  logic [31:0]       rdata_r;
  logic              ack_r;
  logic              err_r;
  logic              led_we_s;
  logic              edge_we_s;
  logic              mask_we_s;
  reg_sel_e          sel_s;
  logic              unused_s;

  assign unused_s = &{1'b0, bus.wdata[31:NUM_SW]};

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .pin   (sw_pins[i]),
      .stable(stable_s[i]),
      .rise  (rise_s[i])
    );
  end

  // Decode, write strobes, edge-status next state and read mux.
  always_comb begin
    sel_s     = decode_addr(BASE_ADDR, bus.addr, IRQ_EN);
    led_we_s  = bus.req && bus.we && (sel_s == SEL_LED);
    edge_we_s = bus.req && bus.we && (sel_s == SEL_EDGE);
    mask_we_s = bus.req && bus.we && (sel_s == SEL_IRQ_MASK);
    clr_s     = edge_we_s ? bus.wdata[NUM_SW-1:0] : {NUM_SW{1'b0}};
    // A rise in the same cycle as a clear keeps the bit set.
    edge_next_s = (edge_r & ~clr_s) | rise_s;
    rd_data_s   = 32'h0000_0000;
    case (sel_s)
      SEL_SWITCH:   rd_data_s = 32'(stable_s);
      SEL_LED:      rd_data_s = 32'(led_r);
      SEL_EDGE:     rd_data_s = 32'(edge_r);
      SEL_IRQ_MASK: rd_data_s = 32'(mask_s);
      default:      rd_data_s = 32'h0000_0000;
    endcase
  end

  // LED and edge-status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_r  <= {NUM_SW{1'b0}};
      edge_r <= {NUM_SW{1'b0}};
    end else begin
      if (led_we_s) begin
        led_r <= bus.wdata[NUM_SW-1:0];
      end
      edge_r <= edge_next_s;
    end
  end

  // Registered response: one ack per request, data only on good loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ack_r   <= bus.req;
      err_r   <= bus.req && (sel_s == SEL_NONE);
      rdata_r <= (bus.req && !bus.we && (sel_s != SEL_NONE)) ? rd_data_s : 32'h0000_0000;
    end
  end

`ifdef SWITCH_IRQ_EN
  logic [NUM_SW-1:0] mask_r;
  logic              irq_r;

  // Interrupt mask and registered interrupt request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_r <= {NUM_SW{1'b0}};
      irq_r  <= 1'b0;
    end else begin
      if (mask_we_s) begin
        mask_r <= bus.wdata[NUM_SW-1:0];
      end
      irq_r <= |(edge_r & mask_r);
    end
  end

  assign mask_s = mask_r;
  assign irq    = irq_r;
`else
  logic unused_mask_s;
  assign unused_mask_s = mask_we_s;
  assign mask_s        = {NUM_SW{1'b0}};
  assign irq           = 1'b0;
`endif

  assign bus.ack   = ack_r;
  assign bus.err   = err_r;
  assign bus.rdata = rdata_r;
  assign led_pins  = led_r;

endmodule
